bus_arbiter: RTL and testbench

- Two-master arbiter in front of the single-port memory block.
- Masters are the CPU core's memory port and the DMA engine.
- CPU has priority. DMA gets idle slots, plus a forced slot after a bounded starvation time.
- Routes read data back to the master that issued the read, and generates the CPU-side wait.

---
 rtl/bus_arbiter_if.sv | 51 +++++
 rtl/bus_arbiter.sv | 127 ++++++++++++
 tb/tb_bus_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_if.sv
// Bus bundle between the two requesting masters (CPU, DMA), the arbiter and the
// single-port memory. The slave modport is the arbiter's view; master is the outside world.
interface bus_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_byte_en;
  logic              cpu_byte_sel;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rvalid;
  logic              cpu_wait;

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_gnt;
  logic [DATA_W-1:0] dma_rdata;
  logic              dma_rvalid;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_byte_enable;
  logic              mem_byte_select;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_wait;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_byte_en, cpu_byte_sel,
    output cpu_rdata, cpu_rvalid, cpu_wait,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_gnt, dma_rdata, dma_rvalid,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_byte_enable, mem_byte_select,
    input  mem_rdata, mem_wait
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_byte_en, cpu_byte_sel,
    input  cpu_rdata, cpu_rvalid, cpu_wait,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_gnt, dma_rdata, dma_rvalid,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_byte_enable, mem_byte_select,
    output mem_rdata, mem_wait
  );
endinterface

// File: rtl/bus_arbiter.sv
// CPU/DMA arbiter for the single-port memory: CPU-priority with a starvation-forced
// DMA slot, grant hold while the memory stalls, and read-data routing to the issuer.
module bus_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 8
) (
  input  logic         clk,
  input  logic         rst,
  bus_arbiter_if.slave bus
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DMA} owner_e;

  typedef struct packed {
    logic              en;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              byte_en;
    logic              byte_sel;
  } mem_cmd_t;

  logic [7:0] starve_cnt;
  owner_e     rd_owner;
  mem_cmd_t   held_cmd;
  mem_cmd_t   live_cmd;
  mem_cmd_t   out_cmd;
  logic       cpu_win;
  logic       dma_win;

  // DMA takes the slot when it is alone or has been denied long enough.
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default first,
    // so no path through the block can infer a latch.
    cpu_win = 1'b0;
    dma_win = 1'b0;
    if (!bus.mem_wait) begin
      if (bus.dma_req && (!bus.cpu_req || starve_cnt >= LIMIT)) begin
        dma_win = 1'b1;
      end else if (bus.cpu_req) begin
        cpu_win = 1'b1;
      end
    end
  end

  always_comb begin
    live_cmd = '0;
    if (cpu_win) begin
      live_cmd.en       = 1'b1;
      live_cmd.we       = bus.cpu_we;
      live_cmd.addr     = bus.cpu_addr;
      live_cmd.wdata    = bus.cpu_wdata;
      live_cmd.byte_en  = bus.cpu_byte_en;
      live_cmd.byte_sel = bus.cpu_byte_sel;
    end else if (dma_win) begin
      live_cmd.en       = 1'b1;
      live_cmd.we       = bus.dma_we;
      live_cmd.addr     = bus.dma_addr;
      live_cmd.wdata    = bus.dma_wdata;
    end
  end

  // A stalled memory keeps seeing the access it was handed last cycle.
  assign out_cmd = bus.mem_wait ? held_cmd : live_cmd;

  // Reset is synchronous, so the outputs are forced low while rst is high too;
  // otherwise they would reflect stale state during the reset cycle itself.
  always_comb begin
    bus.mem_en          = 1'b0;
    bus.mem_we          = 1'b0;
    bus.mem_addr        = '0;
    bus.mem_wdata       = '0;
    bus.mem_byte_enable = 1'b0;
    bus.mem_byte_select = 1'b0;
    bus.cpu_wait        = 1'b0;
    bus.cpu_rvalid      = 1'b0;
    bus.cpu_rdata       = '0;
    bus.dma_gnt         = 1'b0;
    bus.dma_rvalid      = 1'b0;
    bus.dma_rdata       = '0;
    if (!rst) begin
      bus.mem_en          = out_cmd.en;
      bus.mem_we          = out_cmd.we;
      bus.mem_addr        = out_cmd.addr;
      bus.mem_wdata       = out_cmd.wdata;
      bus.mem_byte_enable = out_cmd.byte_en;
      bus.mem_byte_select = out_cmd.byte_sel;
      bus.cpu_wait        = bus.cpu_req && !cpu_win;
      bus.dma_gnt         = dma_win;
      bus.cpu_rvalid      = (rd_owner == OWN_CPU);
      bus.dma_rvalid      = (rd_owner == OWN_DMA);
      if (rd_owner == OWN_CPU) bus.cpu_rdata = bus.mem_rdata;
      if (rd_owner == OWN_DMA) bus.dma_rdata = bus.mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      starve_cnt <= '0;
      rd_owner   <= OWN_NONE;
      held_cmd   <= '0;
    end else begin
      if (!bus.dma_req || dma_win) begin
        starve_cnt <= '0;
      end else if (!bus.mem_wait && starve_cnt != 8'hFF) begin
        starve_cnt <= starve_cnt + 8'd1;
      end

      if (!bus.mem_wait) begin
        held_cmd <= live_cmd;
        if (cpu_win && !bus.cpu_we) begin
          rd_owner <= OWN_CPU;
        end else if (dma_win && !bus.dma_we) begin
          rd_owner <= OWN_DMA;
        end else begin
          rd_owner <= OWN_NONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: a behavioural memory, a cycle model of the arbitration rules
// checked every cycle, and directed scenarios with hand-computed literal expectations.
module tb_bus_arbiter;

  localparam int ADDR_W       = 16;
  localparam int DATA_W       = 16;
  localparam int STARVE_LIMIT = 8;
  localparam int MEM_WORDS    = 1024;

  typedef enum int {W_NONE, W_CPU, W_DMA} who_e;

  typedef struct packed {
    logic        en;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        be;
    logic        bs;
  } cmd_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [15:0] init_word(input int i);
    case (i)
      'h0001:  return 16'hAAAA;
      'h0002:  return 16'h5555;
      'h0010:  return 16'h1234;
      default: return 16'(i * 37 + 256);
    endcase
  endfunction

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] wdata,
                                        input logic be, input logic bs);
    if (!be) return wdata;
    return bs ? {wdata[7:0], old[7:0]} : {old[15:8], wdata[7:0]};
  endfunction

  // Behavioural single-port memory: read data appears the cycle after the strobe.
  logic [15:0] mem_img [MEM_WORDS];
  initial begin : memory
    for (int i = 0; i < MEM_WORDS; i++) mem_img[i] = init_word(i);
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      if (bus.mem_en && !bus.mem_wait) begin
        if (bus.mem_we)
          mem_img[bus.mem_addr[9:0]] <= merge(mem_img[bus.mem_addr[9:0]], bus.mem_wdata,
                                              bus.mem_byte_enable, bus.mem_byte_select);
        else
          bus.mem_rdata <= mem_img[bus.mem_addr[9:0]];
      end
    end
  end

  // Cycle model: who owns the memory this cycle, what the memory sees, who gets data back.
  logic [15:0] m_mem [MEM_WORDS];
  initial begin : model
    who_e        win;
    who_e        m_owner;
    cmd_t        e_cmd;
    cmd_t        m_held;
    int          m_cnt;
    logic [15:0] m_rdata;
    logic        s_rst, s_dma_req, s_wait;
    for (int i = 0; i < MEM_WORDS; i++) m_mem[i] = init_word(i);
    m_owner = W_NONE;
    m_held  = '0;
    m_cnt   = 0;
    m_rdata = '0;
    forever begin
      @(negedge clk);
      s_rst     = rst;
      s_dma_req = bus.dma_req;
      s_wait    = bus.mem_wait;
      if (s_rst || s_wait) win = W_NONE;
      else if (s_dma_req && (!bus.cpu_req || m_cnt >= STARVE_LIMIT)) win = W_DMA;
      else if (bus.cpu_req) win = W_CPU;
      else win = W_NONE;

      if (win == W_CPU)
        e_cmd = '{1'b1, bus.cpu_we, bus.cpu_addr, bus.cpu_wdata, bus.cpu_byte_en, bus.cpu_byte_sel};
      else if (win == W_DMA)
        e_cmd = '{1'b1, bus.dma_we, bus.dma_addr, bus.dma_wdata, 1'b0, 1'b0};
      else if (!s_rst && s_wait)
        e_cmd = m_held;
      else
        e_cmd = '0;

      check("model_mem_en",          32'(bus.mem_en),          32'(e_cmd.en));
      check("model_mem_we",          32'(bus.mem_we),          32'(e_cmd.we));
      check("model_mem_addr",        32'(bus.mem_addr),        32'(e_cmd.addr));
      check("model_mem_wdata",       32'(bus.mem_wdata),       32'(e_cmd.wdata));
      check("model_mem_byte_enable", 32'(bus.mem_byte_enable), 32'(e_cmd.be));
      check("model_mem_byte_select", 32'(bus.mem_byte_select), 32'(e_cmd.bs));
      check("model_cpu_wait",   32'(bus.cpu_wait),   32'(!s_rst && bus.cpu_req && win != W_CPU));
      check("model_dma_gnt",    32'(bus.dma_gnt),    32'(win == W_DMA));
      check("model_cpu_rvalid", 32'(bus.cpu_rvalid), 32'(!s_rst && m_owner == W_CPU));
      check("model_cpu_rdata",  32'(bus.cpu_rdata),  (!s_rst && m_owner == W_CPU) ? 32'(m_rdata) : 32'd0);
      check("model_dma_rvalid", 32'(bus.dma_rvalid), 32'(!s_rst && m_owner == W_DMA));
      check("model_dma_rdata",  32'(bus.dma_rdata),  (!s_rst && m_owner == W_DMA) ? 32'(m_rdata) : 32'd0);
      check("model_starve_cnt", 32'(dut.starve_cnt), 32'(m_cnt));

      @(posedge clk);
      if (s_rst) begin
        m_cnt   = 0;
        m_owner = W_NONE;
        m_held  = '0;
      end else begin
        if (!s_dma_req || win == W_DMA) m_cnt = 0;
        else if (!s_wait) m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
        if (!s_wait) begin
          m_held  = e_cmd;
          m_owner = W_NONE;
          if (e_cmd.en && !e_cmd.we) begin
            m_owner = win;
            m_rdata = m_mem[e_cmd.addr[9:0]];
          end else if (e_cmd.en) begin
            m_mem[e_cmd.addr[9:0]] = merge(m_mem[e_cmd.addr[9:0]], e_cmd.wdata, e_cmd.be, e_cmd.bs);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_drive(input logic req, input logic we, input logic [15:0] addr,
                           input logic [15:0] wdata, input logic be, input logic bs);
    bus.cpu_req      = req;
    bus.cpu_we       = we;
    bus.cpu_addr     = addr;
    bus.cpu_wdata    = wdata;
    bus.cpu_byte_en  = be;
    bus.cpu_byte_sel = bs;
  endtask

  task automatic dma_drive(input logic req, input logic we, input logic [15:0] addr,
                           input logic [15:0] wdata);
    bus.dma_req   = req;
    bus.dma_we    = we;
    bus.dma_addr  = addr;
    bus.dma_wdata = wdata;
  endtask

  initial begin : stim
    logic       gnt_log  [11];
    logic       wait_log [11];
    logic [7:0] cnt_log  [11];
    cpu_drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    dma_drive(1'b0, 1'b0, 16'h0, 16'h0);
    bus.mem_wait = 1'b0;
    rst = 1'b1;

    // Reset state
    @(negedge clk);
    check("reset_mem_en",     32'(bus.mem_en),     32'd0);
    check("reset_cpu_wait",   32'(bus.cpu_wait),   32'd0);
    check("reset_dma_gnt",    32'(bus.dma_gnt),    32'd0);
    check("reset_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
    check("reset_dma_rvalid", 32'(bus.dma_rvalid), 32'd0);
    check("reset_starve_cnt", 32'(dut.starve_cnt), 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk); step();

    // CPU-only read of 0x0010
    cpu_drive(1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, 1'b0);
    @(negedge clk);
    check("cpu_rd_mem_en",   32'(bus.mem_en),   32'd1);
    check("cpu_rd_mem_addr", 32'(bus.mem_addr), 32'h0010);
    check("cpu_rd_cpu_wait", 32'(bus.cpu_wait), 32'd0);
    step();
    cpu_drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    @(negedge clk);
    check("cpu_rd_rvalid",     32'(bus.cpu_rvalid), 32'd1);
    check("cpu_rd_rdata",      32'(bus.cpu_rdata),  32'h1234);
    check("cpu_rd_dma_rvalid", 32'(bus.dma_rvalid), 32'd0);
    step();

    // DMA-only write
    dma_drive(1'b1, 1'b1, 16'h0200, 16'hBEEF);
    @(negedge clk);
    check("dma_wr_gnt",     32'(bus.dma_gnt),         32'd1);
    check("dma_wr_mem_we",  32'(bus.mem_we),          32'd1);
    check("dma_wr_wdata",   32'(bus.mem_wdata),       32'hBEEF);
    check("dma_wr_byte_en", 32'(bus.mem_byte_enable), 32'd0);
    step();
    dma_drive(1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk); step();

    // Continuous contention: DMA forced in on cycle 8 only
    cpu_drive(1'b1, 1'b0, 16'h0040, 16'h0, 1'b0, 1'b0);
    dma_drive(1'b1, 1'b0, 16'h0041, 16'h0);
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      gnt_log[i]  = bus.dma_gnt;
      wait_log[i] = bus.cpu_wait;
      cnt_log[i]  = dut.starve_cnt;
      step();
    end
    cpu_drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    dma_drive(1'b0, 1'b0, 16'h0, 16'h0);
    for (int i = 0; i < 11; i++) begin
      check($sformatf("contend_dma_gnt_c%0d", i),  32'(gnt_log[i]),  32'(i == 8));
      check($sformatf("contend_cpu_wait_c%0d", i), 32'(wait_log[i]), 32'(i == 8));
    end
    check("contend_cnt_c8", 32'(cnt_log[8]), 32'd8);
    check("contend_cnt_c9", 32'(cnt_log[9]), 32'd0);
    @(negedge clk); step();

    // CPU byte write stalled by mem_wait for three cycles, DMA waiting alongside
    cpu_drive(1'b1, 1'b1, 16'h0030, 16'h12AB, 1'b1, 1'b1);
    dma_drive(1'b1, 1'b0, 16'h0050, 16'h0);
    @(negedge clk);
    check("bw_grant_cpu_wait", 32'(bus.cpu_wait), 32'd0);
    check("bw_grant_dma_gnt",  32'(bus.dma_gnt),  32'd0);
    step();
    bus.mem_wait = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("stall%0d_mem_en", i),   32'(bus.mem_en),          32'd1);
      check($sformatf("stall%0d_mem_we", i),   32'(bus.mem_we),          32'd1);
      check($sformatf("stall%0d_addr", i),     32'(bus.mem_addr),        32'h0030);
      check($sformatf("stall%0d_wdata", i),    32'(bus.mem_wdata),       32'h12AB);
      check($sformatf("stall%0d_byte_en", i),  32'(bus.mem_byte_enable), 32'd1);
      check($sformatf("stall%0d_byte_sel", i), 32'(bus.mem_byte_select), 32'd1);
      check($sformatf("stall%0d_cpu_wait", i), 32'(bus.cpu_wait),        32'd1);
      check($sformatf("stall%0d_dma_gnt", i),  32'(bus.dma_gnt),         32'd0);
      check($sformatf("stall%0d_cnt", i),      32'(dut.starve_cnt),      32'd1);
      step();
    end
    bus.mem_wait = 1'b0;
    cpu_drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    @(negedge clk);
    check("resume_dma_gnt",  32'(bus.dma_gnt),         32'd1);
    check("resume_addr",     32'(bus.mem_addr),        32'h0050);
    check("resume_byte_en",  32'(bus.mem_byte_enable), 32'd0);
    step();
    dma_drive(1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk); step();

    // Alternating reads: CPU 0x0001 then DMA 0x0002
    cpu_drive(1'b1, 1'b0, 16'h0001, 16'h0, 1'b0, 1'b0);
    @(negedge clk);
    check("alt_cpu_wait", 32'(bus.cpu_wait), 32'd0);
    step();
    cpu_drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    dma_drive(1'b1, 1'b0, 16'h0002, 16'h0);
    @(negedge clk);
    check("alt_dma_gnt",        32'(bus.dma_gnt),    32'd1);
    check("alt_cpu_rvalid",     32'(bus.cpu_rvalid), 32'd1);
    check("alt_cpu_rdata",      32'(bus.cpu_rdata),  32'hAAAA);
    check("alt_dma_rvalid_lo",  32'(bus.dma_rvalid), 32'd0);
    step();
    dma_drive(1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    check("alt_dma_rvalid",     32'(bus.dma_rvalid), 32'd1);
    check("alt_dma_rdata",      32'(bus.dma_rdata),  32'h5555);
    check("alt_cpu_rvalid_lo",  32'(bus.cpu_rvalid), 32'd0);
    check("alt_cpu_rdata_zero", 32'(bus.cpu_rdata),  32'd0);
    step();

    // Reset in the cycle after a DMA read grant, with both masters requesting
    dma_drive(1'b1, 1'b0, 16'h0002, 16'h0);
    @(negedge clk);
    check("rstmid_grant", 32'(bus.dma_gnt), 32'd1);
    step();
    rst = 1'b1;
    cpu_drive(1'b1, 1'b0, 16'h0003, 16'h0, 1'b0, 1'b0);
    dma_drive(1'b1, 1'b0, 16'h0004, 16'h0);
    @(negedge clk);
    check("rstmid_dma_rvalid", 32'(bus.dma_rvalid), 32'd0);
    check("rstmid_dma_rdata",  32'(bus.dma_rdata),  32'd0);
    check("rstmid_mem_en",     32'(bus.mem_en),     32'd0);
    check("rstmid_cpu_wait",   32'(bus.cpu_wait),   32'd0);
    check("rstmid_dma_gnt",    32'(bus.dma_gnt),    32'd0);
    step();
    rst = 1'b0;
    cpu_drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    dma_drive(1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    check("post_rst_dma_rvalid", 32'(bus.dma_rvalid), 32'd0);
    check("post_rst_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
    check("post_rst_cnt",        32'(dut.starve_cnt), 32'd0);
    step();

    // Mixed traffic on a small address window, checked by the model alone
    for (int k = 0; k < 150; k++) begin
      rst          = ($urandom_range(0, 39) == 0);
      bus.mem_wait = ($urandom_range(0, 4) == 0);
      cpu_drive(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                16'($urandom_range(0, 15)), 16'($urandom), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)));
      dma_drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                16'($urandom_range(0, 15)), 16'($urandom));
      @(negedge clk);
      step();
    end

    rst = 1'b0;
    bus.mem_wait = 1'b0;
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, expected finish before 200000");
    $fatal(1, "simulation timeout");
  end

endmodule
